// File: rtl/ntt_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ntt_pkg : shared constants, FSM encoding, zeta ROM and mod-q arithmetic    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package ntt_pkg;

  localparam int Q     = 3329;
  localparam int N     = 256;
  localparam int N_INV = 3303;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COMPUTE = 2'd1,
    ST_SCALE   = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  // zetas[k] = 17^bitrev7(k) mod q
  localparam int c_zetas [128] = '{
       1, 1729, 2580, 3289, 2642,  630, 1897,  848,
    1062, 1919,  193,  797, 2786, 3260,  569, 1746,
     296, 2447, 1339, 1476, 3046,   56, 2240, 1333,
    1426, 2094,  535, 2882, 2393, 2879, 1974,  821,
     289,  331, 3253, 1756, 1197, 2304, 2277, 2055,
     650, 1977, 2513,  632, 2865,   33, 1320, 1915,
    2319, 1435,  807,  452, 1438, 2868, 1534, 2402,
    2647, 2617, 1481,  648, 2474, 3110, 1227,  910,
      17, 2761,  583, 2649, 1637,  723, 2288, 1100,
    1409, 2662, 3281,  233,  756, 2156, 3015, 3050,
    1703, 1651, 2789, 1789, 1847,  952, 1461, 2687,
     939, 2308, 2437, 2388,  733, 2337,  268,  641,
    1584, 2298, 2037, 3220,  375, 2549, 2090, 1645,
    1063,  319, 2773,  757, 2099,  561, 2466, 2594,
    2804, 1092,  403, 1026, 1143, 2150, 2775,  886,
    1722, 1212, 1874, 1029, 2110, 2935,  885, 2154
  };

  function automatic logic [15:0] mod_add(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= 17'(Q)) s = s - 17'(Q);
    return s[15:0];
  endfunction

  function automatic logic [15:0] mod_sub(input logic [15:0] a, input logic [15:0] b);
    if (a >= b) return a - b;
    return a + 16'(Q) - b;
  endfunction

  function automatic logic [15:0] mod_mul(input logic [15:0] a, input logic [15:0] b);
    logic [31:0] p;
    p = {16'd0, a} * {16'd0, b};
    return 16'(p % 32'(Q));
  endfunction

endpackage
`default_nettype wire

// File: rtl/ntt_butterfly.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ntt_butterfly : combinational Cooley-Tukey and Gentleman-Sande butterflies |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module ntt_butterfly
  import ntt_pkg::*;
(
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic [15:0] zeta,
  output logic [15:0] ct_j,
  output logic [15:0] ct_jl,
  output logic [15:0] gs_j,
  output logic [15:0] gs_jl
);

  logic [15:0] w_t;

  assign w_t   = mod_mul(zeta, b);
  assign ct_j  = mod_add(a, w_t);
  assign ct_jl = mod_sub(a, w_t);
  assign gs_j  = mod_add(a, b);
  assign gs_jl = mod_mul(zeta, mod_sub(b, a));

endmodule
`default_nettype wire

// File: rtl/ntt_top.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ntt_top : in-place 256-point NTT / INTT engine mod 3329 with debug ports   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module ntt_top
  import ntt_pkg::*;
#(
  parameter int WIDTH_ADDR_BUTTERFLY = 8,
  parameter int WIDTH_ADDR_ZETAS     = 7,
  parameter int WIDTH                = 16
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  input  logic                            is_ntt,
  output logic                            done_compute,
  output logic                            done_store,
  output logic [WIDTH_ADDR_BUTTERFLY-1:0] addr_j,
  output logic [WIDTH_ADDR_BUTTERFLY-1:0] addr_jl,
  output logic [WIDTH_ADDR_ZETAS-1:0]     addr_zetas,
  output logic [WIDTH-1:0]                zetas,
  output logic [WIDTH-1:0]                Bin_a,
  output logic [WIDTH-1:0]                Bin_b,
  output logic [WIDTH-1:0]                out_j_ntt,
  output logic [WIDTH-1:0]                out_jl_ntt,
  output logic [WIDTH-1:0]                out_j_intt,
  output logic [WIDTH-1:0]                out_jl_intt,
  output logic [WIDTH-1:0]                Bo_a,
  output logic [WIDTH-1:0]                Bo_b,
  output logic [WIDTH_ADDR_BUTTERFLY-1:0] waddr_a,
  output logic [WIDTH_ADDR_BUTTERFLY-1:0] waddr_b,
  output logic                            valid_addr,
  output logic                            done_addr,
  output logic                            valid,
  output logic                            owrite_en,
  output logic [1:0]                      check_state,
  output logic [8191:0]                   data_bram
);

  state_t      r_state;
  logic        r_is_ntt;
  logic        r_done_compute;
  logic [7:0]  r_len;
  logic [7:0]  r_start;
  logic [7:0]  r_j;
  logic [6:0]  r_k;
  logic [6:0]  r_sc;
  logic [15:0] r_mem [256];

  logic w_compute, w_scale, w_grp_end, w_layer_end, w_last;

  assign w_compute   = (r_state == ST_COMPUTE);
  assign w_scale     = (r_state == ST_SCALE);
  assign w_grp_end   = ({1'b0, r_j} + 9'd1) == ({1'b0, r_start} + {1'b0, r_len});
  assign w_layer_end = w_grp_end && (({1'b0, r_start} + {r_len, 1'b0}) == 9'd256);
  assign w_last      = w_layer_end && (r_is_ntt ? (r_len == 8'd2) : (r_len == 8'd128));

  // Addresses are forced to zero outside the active phases so idle ports stay quiet
  always_comb begin
    addr_j     = '0;
    addr_jl    = '0;
    addr_zetas = '0;
    if (w_compute) begin
      addr_j     = r_j;
      addr_jl    = r_j + r_len;
      addr_zetas = r_k;
    end else if (w_scale) begin
      addr_j  = {r_sc, 1'b0};
      addr_jl = {r_sc, 1'b1};
    end
  end

  assign zetas = 16'(c_zetas[addr_zetas]);
  assign Bin_a = r_mem[addr_j];
  assign Bin_b = r_mem[addr_jl];

  ntt_butterfly u_butterfly (
    .a     (Bin_a),
    .b     (Bin_b),
    .zeta  (zetas),
    .ct_j  (out_j_ntt),
    .ct_jl (out_jl_ntt),
    .gs_j  (out_j_intt),
    .gs_jl (out_jl_intt)
  );

  assign Bo_a = w_scale ? mod_mul(Bin_a, 16'(N_INV)) : (r_is_ntt ? out_j_ntt  : out_j_intt);
  assign Bo_b = w_scale ? mod_mul(Bin_b, 16'(N_INV)) : (r_is_ntt ? out_jl_ntt : out_jl_intt);

  assign waddr_a      = addr_j;
  assign waddr_b      = addr_jl;
  assign valid_addr   = w_compute;
  assign done_addr    = w_compute && w_last;
  assign valid        = w_compute || w_scale;
  assign owrite_en    = valid;
  assign check_state  = r_state;
  assign done_store   = (r_state == ST_DONE);
  assign done_compute = r_done_compute;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state        <= ST_IDLE;
      r_is_ntt       <= 1'b0;
      r_done_compute <= 1'b0;
      r_len          <= '0;
      r_start        <= '0;
      r_j            <= '0;
      r_k            <= '0;
      r_sc           <= '0;
      for (int i = 0; i < N; i++) r_mem[i] <= 16'(i);
    end else begin
      r_done_compute <= 1'b0;
      if (owrite_en) begin
        r_mem[waddr_a] <= Bo_a;
        r_mem[waddr_b] <= Bo_b;
      end
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            r_state  <= ST_COMPUTE;
            r_is_ntt <= is_ntt;
            r_len    <= is_ntt ? 8'd128 : 8'd2;
            r_k      <= is_ntt ? 7'd1 : 7'd127;
            r_start  <= '0;
            r_j      <= '0;
          end
        end
        ST_COMPUTE: begin
          if (!w_grp_end) begin
            r_j <= r_j + 8'd1;
          end else begin
            r_k <= r_is_ntt ? r_k + 7'd1 : r_k - 7'd1;
            if (!w_layer_end) begin
              r_start <= r_start + {r_len[6:0], 1'b0};
              r_j     <= r_start + {r_len[6:0], 1'b0};
            end else begin
              r_len   <= r_is_ntt ? {1'b0, r_len[7:1]} : {r_len[6:0], 1'b0};
              r_start <= '0;
              r_j     <= '0;
            end
          end
          if (w_last) begin
            r_done_compute <= 1'b1;
            r_state        <= r_is_ntt ? ST_DONE : ST_SCALE;
            r_sc           <= '0;
          end
        end
        ST_SCALE: begin
          r_sc <= r_sc + 7'd1;
          if (r_sc == 7'd127) r_state <= ST_DONE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_bram
    assign data_bram[(gi+1)*32-1 -: 32] = {16'd0, r_mem[gi]};
  end

endmodule
`default_nettype wire

// File: tb/tb_ntt_top.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_ntt_top : randomized self-checking bench against a software NTT model   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_ntt_top;

  localparam int Q = 3329;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          is_ntt = 1'b0;
  logic          done_compute, done_store, valid_addr, done_addr, valid, owrite_en;
  logic [7:0]    addr_j, addr_jl, waddr_a, waddr_b;
  logic [6:0]    addr_zetas;
  logic [15:0]   zetas, Bin_a, Bin_b, out_j_ntt, out_jl_ntt, out_j_intt, out_jl_intt, Bo_a, Bo_b;
  logic [1:0]    check_state;
  logic [8191:0] data_bram;

  int vectors = 0;
  int errors  = 0;
  int model [256];

  always #5 clk = ~clk;

  ntt_top dut (
    .clk(clk), .rst_n(rst_n), .start(start), .is_ntt(is_ntt),
    .done_compute(done_compute), .done_store(done_store),
    .addr_j(addr_j), .addr_jl(addr_jl), .addr_zetas(addr_zetas), .zetas(zetas),
    .Bin_a(Bin_a), .Bin_b(Bin_b),
    .out_j_ntt(out_j_ntt), .out_jl_ntt(out_jl_ntt),
    .out_j_intt(out_j_intt), .out_jl_intt(out_jl_intt),
    .Bo_a(Bo_a), .Bo_b(Bo_b), .waddr_a(waddr_a), .waddr_b(waddr_b),
    .valid_addr(valid_addr), .done_addr(done_addr), .valid(valid), .owrite_en(owrite_en),
    .check_state(check_state), .data_bram(data_bram)
  );

  // ---------------- reference model ----------------
  function automatic int zeta(int k);
    int e = 0;
    int r = 1;
    for (int i = 0; i < 7; i++) e |= ((k >> i) & 1) << (6 - i);
    for (int i = 0; i < e; i++) r = (r * 17) % Q;
    return r;
  endfunction

  function automatic void model_identity();
    for (int i = 0; i < 256; i++) model[i] = i;
  endfunction

  function automatic void model_ntt();
    int k = 1;
    for (int len = 128; len >= 2; len /= 2)
      for (int s = 0; s < 256; s += 2 * len) begin
        int z = zeta(k);
        k++;
        for (int j = s; j < s + len; j++) begin
          int t = (z * model[j + len]) % Q;
          model[j + len] = (model[j] - t + Q) % Q;
          model[j]       = (model[j] + t) % Q;
        end
      end
  endfunction

  function automatic void model_intt();
    int k = 127;
    for (int len = 2; len <= 128; len *= 2)
      for (int s = 0; s < 256; s += 2 * len) begin
        int z = zeta(k);
        k--;
        for (int j = s; j < s + len; j++) begin
          int t = model[j];
          model[j]       = (t + model[j + len]) % Q;
          model[j + len] = (z * ((model[j + len] - t + Q) % Q)) % Q;
        end
      end
    for (int i = 0; i < 256; i++) model[i] = (model[i] * 3303) % Q;
  endfunction

  function automatic logic [31:0] word(int i);
    return data_bram[i*32 +: 32];
  endfunction

  function automatic int mem_diffs(output int first);
    int n = 0;
    first = -1;
    for (int i = 0; i < 256; i++)
      if (word(i) !== 32'(model[i])) begin
        if (n == 0) first = i;
        n++;
      end
    return n;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic kick(input bit ntt);
    start = 1'b1;
    is_ntt = ntt;
    step();
    start = 1'b0;
    is_ntt = 1'($urandom_range(0, 1));
  endtask

  // Runs from the first COMPUTE cycle to DONE; optionally pulses start mid-run.
  task automatic finish_run(input int glitch_at, output int n_comp, output int da_at,
                            output logic [1:0] st_after, output logic dc_after,
                            output logic ds_after, output int n_scale);
    n_comp = 0;
    da_at = -1;
    n_scale = 0;
    while (check_state == 2'd1 && n_comp < 1200) begin
      n_comp++;
      if (done_addr) da_at = n_comp;
      if (n_comp == glitch_at) begin
        start = 1'b1;
        is_ntt = ~is_ntt;
      end
      step();
      start = 1'b0;
    end
    st_after = check_state;
    dc_after = done_compute;
    ds_after = done_store;
    while (check_state == 2'd2 && n_scale < 300) begin
      n_scale++;
      step();
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    start = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    model_identity();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    step();
    vectors++; if (check_state !== 2'd0) begin errors++; $display("FAIL reset_state got %0d want 0", check_state); end
    vectors++; if (done_store !== 1'b0) begin errors++; $display("FAIL reset_done_store got %0b want 0", done_store); end
    vectors++; if (owrite_en !== 1'b0 || valid !== 1'b0) begin errors++; $display("FAIL reset_write got we=%0b valid=%0b want 0", owrite_en, valid); end
    vectors++; if (addr_j !== 8'd0 || addr_jl !== 8'd0 || addr_zetas !== 7'd0) begin errors++; $display("FAIL reset_addr got %0d/%0d/%0d want 0", addr_j, addr_jl, addr_zetas); end
    vectors++; if (word(5) !== 32'h5) begin errors++; $display("FAIL reset_word5 got %h want 00000005", word(5)); end
  endtask

  task automatic test_ntt_full();
    int nc, da, ns, nd, first;
    logic [1:0] st;
    logic dc, ds;
    kick(1'b1);
    vectors++; if (addr_j !== 8'd0 || addr_jl !== 8'd128) begin errors++; $display("FAIL ntt0_addr got %0d/%0d want 0/128", addr_j, addr_jl); end
    vectors++; if (addr_zetas !== 7'd1 || zetas !== 16'd1729) begin errors++; $display("FAIL ntt0_zeta got k=%0d z=%0d want 1/1729", addr_zetas, zetas); end
    vectors++; if (Bin_b !== 16'd128) begin errors++; $display("FAIL ntt0_bin_b got %0d want 128", Bin_b); end
    vectors++; if (Bo_a !== 16'd1598 || Bo_b !== 16'd1731) begin errors++; $display("FAIL ntt0_bo got %0d/%0d want 1598/1731", Bo_a, Bo_b); end
    vectors++; if (valid_addr !== 1'b1 || owrite_en !== 1'b1 || waddr_b !== 8'd128) begin errors++; $display("FAIL ntt0_ctrl got va=%0b we=%0b wb=%0d want 1/1/128", valid_addr, owrite_en, waddr_b); end
    finish_run(0, nc, da, st, dc, ds, ns);
    vectors++; if (nc !== 896 || da !== 896) begin errors++; $display("FAIL ntt_cycles got comp=%0d done_addr_at=%0d want 896/896", nc, da); end
    vectors++; if (st !== 2'd3 || dc !== 1'b1 || ds !== 1'b1) begin errors++; $display("FAIL ntt_done got st=%0d dc=%0b ds=%0b want 3/1/1", st, dc, ds); end
    model_ntt();
    nd = mem_diffs(first);
    vectors++; if (nd != 0) begin errors++; $display("FAIL ntt_mem got %0d bad words, first %0d = %0d want %0d", nd, first, word(first), model[first]); end
  endtask

  task automatic test_intt_restart();
    int nc, da, ns, nd, first;
    logic [1:0] st;
    logic dc, ds;
    kick(1'b0);
    vectors++; if (done_store !== 1'b0 || check_state !== 2'd1) begin errors++; $display("FAIL restart_accept got ds=%0b st=%0d want 0/1", done_store, check_state); end
    finish_run(0, nc, da, st, dc, ds, ns);
    vectors++; if (nc !== 896 || st !== 2'd2 || dc !== 1'b1 || ds !== 1'b0) begin errors++; $display("FAIL intt_compute got comp=%0d st=%0d dc=%0b ds=%0b want 896/2/1/0", nc, st, dc, ds); end
    vectors++; if (ns !== 128 || check_state !== 2'd3 || done_store !== 1'b1 || done_compute !== 1'b0) begin errors++; $display("FAIL intt_scale got scale=%0d st=%0d ds=%0b dc=%0b want 128/3/1/0", ns, check_state, done_store, done_compute); end
    model_identity();
    nd = mem_diffs(first);
    vectors++; if (nd != 0) begin errors++; $display("FAIL roundtrip_mem got %0d bad words, first %0d = %0d want %0d", nd, first, word(first), model[first]); end
  endtask

  task automatic test_intt_from_reset();
    int nc, da, ns, nd, first;
    logic [1:0] st;
    logic dc, ds;
    do_reset();
    kick(1'b0);
    vectors++; if (addr_j !== 8'd0 || addr_jl !== 8'd2 || addr_zetas !== 7'd127) begin errors++; $display("FAIL intt0_addr got %0d/%0d/%0d want 0/2/127", addr_j, addr_jl, addr_zetas); end
    vectors++; if (out_j_intt !== 16'd2 || out_jl_intt !== 16'((zeta(127) * 2) % Q)) begin errors++; $display("FAIL intt0_bfly got %0d/%0d want 2/%0d", out_j_intt, out_jl_intt, (zeta(127) * 2) % Q); end
    finish_run(0, nc, da, st, dc, ds, ns);
    vectors++; if (nc + ns !== 1024 || done_store !== 1'b1) begin errors++; $display("FAIL intt_len got %0d cycles ds=%0b want 1024/1", nc + ns, done_store); end
    model_intt();
    nd = mem_diffs(first);
    vectors++; if (nd != 0) begin errors++; $display("FAIL intt_mem got %0d bad words, first %0d = %0d want %0d", nd, first, word(first), model[first]); end
  endtask

  task automatic test_mid_start();
    int nc, da, ns, nd, first;
    logic [1:0] st;
    logic dc, ds;
    do_reset();
    kick(1'b1);
    finish_run(int'($urandom_range(2, 890)), nc, da, st, dc, ds, ns);
    vectors++; if (nc !== 896 || da !== 896 || st !== 2'd3) begin errors++; $display("FAIL midstart_cycles got comp=%0d da=%0d st=%0d want 896/896/3", nc, da, st); end
    model_ntt();
    nd = mem_diffs(first);
    vectors++; if (nd != 0) begin errors++; $display("FAIL midstart_mem got %0d bad words, first %0d = %0d want %0d", nd, first, word(first), model[first]); end
  endtask

  task automatic test_mid_reset();
    int stop_at, nd, first;
    kick(1'($urandom_range(0, 1)));
    stop_at = int'($urandom_range(1, 880));
    for (int i = 0; i < stop_at; i++) step();
    rst_n = 1'b0;
    step();
    model_identity();
    vectors++; if (check_state !== 2'd0 || owrite_en !== 1'b0 || done_store !== 1'b0) begin errors++; $display("FAIL midreset_state got st=%0d we=%0b ds=%0b want 0/0/0", check_state, owrite_en, done_store); end
    nd = mem_diffs(first);
    vectors++; if (nd != 0) begin errors++; $display("FAIL midreset_mem got %0d bad words, first %0d = %0d want %0d", nd, first, word(first), model[first]); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_back_to_back();
    int nc, da, ns, nd, first, gap;
    logic [1:0] st;
    logic dc, ds;
    bit ntt;
    for (int r = 0; r < 4; r++) begin
      gap = int'($urandom_range(0, 4));
      for (int i = 0; i < gap; i++) step();
      ntt = 1'($urandom_range(0, 1));
      kick(ntt);
      finish_run(0, nc, da, st, dc, ds, ns);
      if (ntt) model_ntt(); else model_intt();
      vectors++; if (check_state !== 2'd3 || nc + ns !== (ntt ? 896 : 1024)) begin errors++; $display("FAIL b2b_%0d_len got st=%0d cycles=%0d want 3/%0d", r, check_state, nc + ns, ntt ? 896 : 1024); end
      nd = mem_diffs(first);
      vectors++; if (nd != 0) begin errors++; $display("FAIL b2b_%0d_mem got %0d bad words, first %0d = %0d want %0d", r, nd, first, word(first), model[first]); end
    end
  endtask

  initial begin
    test_reset();
    test_ntt_full();
    test_intt_restart();
    test_intt_from_reset();
    test_mid_start();
    test_mid_reset();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ntt_top.md
# ntt_top

Self-contained Kyber/ML-KEM number-theoretic transform engine. Runs an in-place forward NTT or inverse NTT (INTT) over one 256-coefficient polynomial mod q = 3329, held in an internal 256×32-bit register memory. Every internal datapath node is exported as a port for waveform debug. It sits below the ML-KEM polynomial arithmetic layer.

## Interface
- WIDTH_ADDR_BUTTERFLY, 8: coefficient address width.
- WIDTH_ADDR_ZETAS, 7: zeta ROM address width.
- WIDTH, 16: coefficient width.
- clk in 1: single clock, rising edge.
- rst_n in 1: reset, synchronous, active-low.
- start in 1: begin transform; sampled in IDLE or DONE.
- is_ntt in 1: 1 = NTT, 0 = INTT; latched when start is accepted.
- done_compute out 1: one-cycle pulse after the last butterfly is written.
- done_store out 1: high in DONE; result is final in memory.
- addr_j, addr_jl out 8: butterfly read addresses j and j+len.
- addr_zetas out 7: zeta ROM index k.
- zetas out 16: ROM[addr_zetas].
- Bin_a, Bin_b out 16: mem[addr_j][15:0], mem[addr_jl][15:0].
- out_j_ntt, out_jl_ntt out 16: Cooley-Tukey butterfly results.
- out_j_intt, out_jl_intt out 16: Gentleman-Sande butterfly results.
- Bo_a, Bo_b out 16: write data, muxed by latched is_ntt (scale result in SCALE).
- waddr_a, waddr_b out 8: write addresses.
- valid_addr out 1: the address generator presents a butterfly this cycle.
- done_addr out 1: high with the final (896th) butterfly address.
- valid out 1: Bo_a/Bo_b are valid this cycle.
- owrite_en out 1: memory write enable.
- check_state out 2: FSM state.
- data_bram out 8192: word i at bits [(i+1)*32-1 -: 32]. Bits [15:0] hold the coefficient; bits [31:16] are 0.

## Operation
- FSM states: IDLE=0, COMPUTE=1, SCALE=2, DONE=3.
  - IDLE→COMPUTE on start.
  - COMPUTE→SCALE after the last butterfly if INTT; COMPUTE→DONE after the last butterfly if NTT.
  - SCALE→DONE after 128 cycles.
  - DONE→COMPUTE on start.
  - start is ignored in COMPUTE and SCALE.
- Reset: state IDLE; mem[i] = i (zero-extended); k and counters cleared. All single-bit outputs are 0 and all address outputs are 0.
- The transform runs in place and no load port exists. A restart transforms the current memory contents.
- NTT order: len = 128, 64, …, 2. For each start = 0, 2len, … < 256: k increments from 1, then j runs start…start+len−1.
  - t = zeta·b; out_j = a+t; out_jl = a−t.
- INTT order: len = 2, 4, …, 128. k decrements from 127, same loop nest.
  - out_j = a+b; out_jl = zeta·(b−a).
- SCALE: cycle i (0…127) handles addresses 2i and 2i+1. Each value becomes value·3303 mod q.
- Arithmetic: all operands lie in [0, q−1].
  - Add: subtract q if sum ≥ q.
  - Subtract: add q if the difference is negative.
  - Multiply: 32-bit product, then full reduction mod q.
- Zeta ROM: zetas[k] = 17^bitrev7(k) mod 3329. zetas[0]=1, zetas[1]=1729, zetas[2]=2580, zetas[3]=3289.

## Timing
- One butterfly per cycle. Memory read, butterfly and zeta ROM are combinational; the write happens on the same clock edge.
- In COMPUTE: valid_addr = valid = owrite_en = 1; waddr_a = addr_j; waddr_b = addr_jl. No hazards exist at layer boundaries.
- start accepted at edge E0 gives COMPUTE for 896 cycles. done_addr is high in the 896th cycle.
- NTT: DONE in the next cycle. done_compute pulses and done_store rises in that same cycle.
- INTT: done_compute pulses in the first SCALE cycle. SCALE lasts 128 cycles, then DONE with done_store = 1.
- done_store drops in the cycle after a restart is accepted.
- Outside COMPUTE and SCALE, valid and owrite_en are 0.
- rst_n low mid-operation returns to IDLE and reinitialises memory at that edge.

## Structure
- Shared package ntt_pkg holds:
  - Q = 3329, N = 256, N_INV = 3303.
  - Zeta ROM constant array.
  - FSM state encoding.
  - Modular add, subtract and multiply functions.
- One sub-module, ntt_butterfly. It is combinational, takes a, b and zeta, and outputs both the CT and GS result pairs.
- The address generator and FSM live in ntt_top.

## Test plan
- Reset, then idle → check_state = 0, done_store = 0, owrite_en = 0, data_bram word 5 = 0x00000005.
- NTT start, first cycle → addr_j = 0, addr_jl = 128, addr_zetas = 1, zetas = 1729, Bin_b = 128, Bo_a = 1598, Bo_b = 1731.
- NTT full run → done_addr in the 896th COMPUTE cycle; done_compute and done_store one cycle later; all words < 3329 and match a software NTT of a[i] = i.
- INTT start from reset → first cycle addr_j = 0, addr_jl = 2, addr_zetas = 127, out_j_intt = 2. Then 896 + 128 cycles to done_store; result matches a software INTT of a[i] = i scaled by 3303.
- NTT then INTT (restart from DONE) → memory returns to a[i] = i.
- rst_n low mid-COMPUTE, and start pulsed mid-COMPUTE → reset: IDLE with mem[i] = i; mid-run start: ignored, cycle count unchanged.
